// File: rtl/conv_bcd_bin_seq_if.sv
// Valid/ready bundle between the RTC read-data path and the BCD-to-binary converter.
// The master side supplies BCD data and consumes results; the slave side is the converter.
interface conv_bcd_bin_seq_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   dato_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      dato_bin;
    logic                  err;

    modport master (
        output in_valid, dato_bcd, out_ready,
        input  in_ready, out_valid, dato_bin, err
    );

    modport slave (
        input  in_valid, dato_bcd, out_ready,
        output in_ready, out_valid, dato_bin, err
    );
endinterface

// File: rtl/conv_bcd_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Define BCD_MAX_CHECK_EN to also reject all-decimal inputs whose value exceeds MAX_VAL.
//
// state | meaning
// IDLE  | ready to accept a BCD word
// SHIFT | shifting/correcting, count holds remaining shifts
// DONE  | result (or rejection) presented until out_ready
module conv_bcd_bin_seq #(
    parameter int DIGITS  = 2,
    parameter int BIN_W   = 7,
    parameter int MAX_VAL = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    conv_bcd_bin_seq_if.slave  bus
);
    localparam int NB = 4 * DIGITS;
    localparam int CW = $clog2(NB + 1);

`ifdef BCD_MAX_CHECK_EN
    localparam bit MAX_CHECK = 1'b1;
`else
    localparam bit MAX_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [2*NB-1:0]   sr, sr_nxt, sr_shift;
    logic [CW-1:0]     count, count_nxt;
    logic [BIN_W-1:0]  bin_q, bin_nxt;
    logic              err_q, err_nxt;
    logic              bad_nibble;
    logic              over_max;
    logic [31:0]       bcd_sum;

    // Input screening: non-decimal nibbles, and the decimal value for the optional max check.
    always_comb begin
        bad_nibble = 1'b0;
        bcd_sum    = 32'd0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (bus.dato_bcd[4*d +: 4] > 4'd9) bad_nibble = 1'b1;
            bcd_sum = bcd_sum * 32'd10 + {28'd0, bus.dato_bcd[4*d +: 4]};
        end
        over_max = MAX_CHECK && (bcd_sum > 32'(MAX_VAL));
    end

    // Shift right, then pull every BCD digit that landed at >=8 back by 3 (no inter-digit carry).
    always_comb begin
        sr_shift = sr >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_shift[NB + 4*d +: 4] >= 4'd8)
                sr_shift[NB + 4*d +: 4] = sr_shift[NB + 4*d +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        count_nxt = count;
        bin_nxt   = bin_q;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bad_nibble || over_max) begin
                        state_nxt = DONE;
                        bin_nxt   = '1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                        sr_nxt    = {bus.dato_bcd, {NB{1'b0}}};
                        count_nxt = CW'(NB);
                    end
                end
            end
            SHIFT: begin
                sr_nxt    = sr_shift;
                count_nxt = count - CW'(1);
                if (count == CW'(1)) begin
                    bin_nxt   = BIN_W'(sr_shift[NB-1:0]);
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            count <= '0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            count <= count_nxt;
            bin_q <= bin_nxt;
            err_q <= err_nxt;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.dato_bin  = bin_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_conv_bcd_bin_seq.sv
// Bench for conv_bcd_bin_seq: a 2-digit instance driven from a vector table plus
// hold/reset sequences, and a 4-digit instance for wide conversions.
module tb_conv_bcd_bin_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_bcd_bin_seq_if #(.DIGITS(2), .BIN_W(7))  bus2 ();
    conv_bcd_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus4 ();

    conv_bcd_bin_seq #(.DIGITS(2), .BIN_W(7), .MAX_VAL(99)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );
    conv_bcd_bin_seq #(.DIGITS(4), .BIN_W(14), .MAX_VAL(9999)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] bin;
        logic       err;
        int         lat;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
        int          lat;
    } vec4_t;

    vec_t  vecs[8];
    vec4_t vecs4[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word on the 2-digit DUT; while busy, keep in_valid high with other data
    // to show it is ignored. Optionally release the result with out_ready.
    task automatic run2(input logic [7:0] bcd, input logic [6:0] exp_bin, input logic exp_err,
                        input int exp_lat, input logic release_now);
        int n = 0;
        chk("in_ready_idle", 32'(bus2.in_ready), 32'd1);
        bus2.out_ready = release_now;
        bus2.in_valid  = 1'b1;
        bus2.dato_bcd  = bcd;
        tick();
        bus2.dato_bcd  = 8'h77;
        while (!bus2.out_valid && n < 40) begin
            chk("in_ready_busy", 32'(bus2.in_ready), 32'd0);
            tick();
            n++;
        end
        bus2.in_valid = 1'b0;
        chk("latency", 32'(n), 32'(exp_lat));
        chk("out_valid", 32'(bus2.out_valid), 32'd1);
        chk("dato_bin", 32'(bus2.dato_bin), 32'(exp_bin));
        chk("err", 32'(bus2.err), 32'(exp_err));
        if (release_now) begin
            tick();
            chk("release_out_valid", 32'(bus2.out_valid), 32'd0);
            chk("release_in_ready", 32'(bus2.in_ready), 32'd1);
            chk("release_bin_kept", 32'(bus2.dato_bin), 32'(exp_bin));
            bus2.out_ready = 1'b0;
        end
    endtask

    task automatic run4(input logic [15:0] bcd, input logic [13:0] exp_bin, input logic exp_err,
                        input int exp_lat);
        int n = 0;
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.dato_bcd  = bcd;
        tick();
        bus4.in_valid  = 1'b0;
        while (!bus4.out_valid && n < 60) begin
            tick();
            n++;
        end
        chk("w_latency", 32'(n), 32'(exp_lat));
        chk("w_dato_bin", 32'(bus4.dato_bin), 32'(exp_bin));
        chk("w_err", 32'(bus4.err), 32'(exp_err));
        tick();
        chk("w_release", 32'(bus4.out_valid), 32'd0);
        bus4.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h59, 7'd59,   1'b0, 8};
        vecs[1] = '{8'h08, 7'd8,    1'b0, 8};
        vecs[2] = '{8'h00, 7'd0,    1'b0, 8};
        vecs[3] = '{8'h99, 7'd99,   1'b0, 8};
        vecs[4] = '{8'h3A, 7'h7F,   1'b1, 0};
        vecs[5] = '{8'h12, 7'd12,   1'b0, 8};
        vecs[6] = '{8'hA0, 7'h7F,   1'b1, 0};
        vecs[7] = '{8'h80, 7'd80,   1'b0, 8};

        vecs4[0] = '{16'h9999, 14'd9999,  1'b0, 16};
        vecs4[1] = '{16'h1234, 14'd1234,  1'b0, 16};
        vecs4[2] = '{16'h0800, 14'd800,   1'b0, 16};
        vecs4[3] = '{16'h12F4, 14'h3FFF,  1'b1, 0};

        bus2.in_valid = 1'b0; bus2.dato_bcd = '0; bus2.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.dato_bcd = '0; bus4.out_ready = 1'b0;

        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", 32'(bus2.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus2.in_ready), 32'd1);
        chk("rst_dato_bin", 32'(bus2.dato_bin), 32'd0);
        chk("rst_err", 32'(bus2.err), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run2(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].lat, 1'b1);

        // Result held for 5 cycles with out_ready low and a competing in_valid.
        run2(8'h45, 7'd45, 1'b0, 8, 1'b0);
        bus2.in_valid = 1'b1;
        bus2.dato_bcd = 8'h12;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(bus2.out_valid), 32'd1);
            chk("hold_bin", 32'(bus2.dato_bin), 32'd45);
            chk("hold_in_ready", 32'(bus2.in_ready), 32'd0);
        end
        bus2.out_ready = 1'b1;
        tick();
        chk("hold_release_valid", 32'(bus2.out_valid), 32'd0);
        chk("hold_release_idle", 32'(bus2.in_ready), 32'd1);
        chk("hold_release_bin", 32'(bus2.dato_bin), 32'd45);
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
        tick();
        chk("no_accept_on_release", 32'(bus2.in_ready), 32'd1);

        // Reset landing mid-SHIFT with three shifts left discards the conversion.
        bus2.in_valid = 1'b1;
        bus2.dato_bcd = 8'h77;
        tick();
        bus2.in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(bus2.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus2.in_ready), 32'd1);
        chk("midrst_dato_bin", 32'(bus2.dato_bin), 32'd0);
        chk("midrst_err", 32'(bus2.err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst_no_result", 32'(bus2.out_valid), 32'd0);
        end
        run2(8'h23, 7'd23, 1'b0, 8, 1'b1);

        for (int i = 0; i < 4; i++)
            run4(vecs4[i].bcd, vecs4[i].bin, vecs4[i].err, vecs4[i].lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
